// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: request flags and FSM states.
package mem_arbiter_pkg;
  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_RESP, ST_GAP} state_t;

  // 2'b11 is illegal and behaves as idle
  function automatic logic is_req(input logic [1:0] f);
    return (f == MEM_READ) || (f == MEM_WRITE);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Upstream requester bundle plus the single downstream controller port.
interface mem_arbiter_if #(
  parameter int PORT_COUNT = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MW = DATA_WIDTH / 8;

  logic [PORT_COUNT-1:0][1:0]            req_rw_flag;
  logic [PORT_COUNT-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [PORT_COUNT-1:0][DATA_WIDTH-1:0] req_write_data;
  logic [PORT_COUNT-1:0][MW-1:0]         req_write_mask;
  logic [PORT_COUNT-1:0][DATA_WIDTH-1:0] req_read_data;
  logic [PORT_COUNT-1:0]                 req_busy;
  logic [PORT_COUNT-1:0]                 req_done;

  logic [1:0]            MEM_rw_flag;
  logic [ADDR_WIDTH-1:0] MEM_addr;
  logic [DATA_WIDTH-1:0] MEM_write_data;
  logic [MW-1:0]         MEM_write_mask;
  logic [DATA_WIDTH-1:0] MEM_read_data;
  logic                  MEM_busy;
  logic                  MEM_done;

  // master: the arbiter, which drives the controller port
  modport master (
    input  req_rw_flag, req_addr, req_write_data, req_write_mask,
    input  MEM_read_data, MEM_busy, MEM_done,
    output req_read_data, req_busy, req_done,
    output MEM_rw_flag, MEM_addr, MEM_write_data, MEM_write_mask
  );

  modport slave (
    output req_rw_flag, req_addr, req_write_data, req_write_mask,
    output MEM_read_data, MEM_busy, MEM_done,
    input  req_read_data, req_busy, req_done,
    input  MEM_rw_flag, MEM_addr, MEM_write_data, MEM_write_mask
  );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first valid index at or above
// the pointer, wrapping around.
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_grant,
  output logic          o_any
);
  always_comb begin
    int idx;
    o_grant = '0;
    o_any   = 1'b0;
    idx     = 0;
    // walk from the farthest offset down so the nearest valid wins
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(i_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (i_valid[idx]) begin
        o_grant = PW'(idx);
        o_any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising PORT_COUNT requesters onto one memory
// controller port, one outstanding transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int PORT_COUNT = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic CLK,
  input logic RST,
  mem_arbiter_if.master bus
);
  localparam int PW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam int MW = DATA_WIDTH / 8;

  state_t                r_state, w_next;
  logic [PW-1:0]         r_ptr, r_gnt, w_pick;
  logic                  w_any;
  logic [PORT_COUNT-1:0] w_valid;
  logic [1:0]            r_flag;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MW-1:0]         r_mask;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < PORT_COUNT; i++) w_valid[i] = is_req(bus.req_rw_flag[i]);
  end

  rr_picker #(.N(PORT_COUNT), .PW(PW)) u_pick (
    .i_valid (w_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!bus.MEM_busy && w_any) w_next = ST_SERVE;
      ST_SERVE: if (bus.MEM_done) w_next = ST_RESP;
      ST_RESP:  w_next = ST_GAP;
      ST_GAP:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_flag  <= MEM_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_next == ST_SERVE) begin
        r_gnt   <= w_pick;
        r_flag  <= bus.req_rw_flag[w_pick];
        r_addr  <= bus.req_addr[w_pick];
        r_wdata <= bus.req_write_data[w_pick];
        r_mask  <= bus.req_write_mask[w_pick];
      end
      if (r_state == ST_RESP)
        r_ptr <= (r_gnt == PW'(PORT_COUNT - 1)) ? '0 : r_gnt + 1'b1;
    end
  end

  // per-port read data capture doubles as the hold-between-transactions register
  for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
    logic [DATA_WIDTH-1:0] r_rdata;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)
        r_rdata <= '0;
      else if (r_state == ST_SERVE && bus.MEM_done && r_gnt == PW'(i))
        r_rdata <= bus.MEM_read_data;
    end
    assign bus.req_read_data[i] = r_rdata;
    assign bus.req_done[i]      = (r_state == ST_RESP) && (r_gnt == PW'(i));
    assign bus.req_busy[i]      = (r_state != ST_IDLE) && (r_gnt != PW'(i));
  end

  assign bus.MEM_rw_flag    = (r_state == ST_SERVE) ? r_flag : MEM_IDLE;
  assign bus.MEM_addr       = r_addr;
  assign bus.MEM_write_data = r_wdata;
  assign bus.MEM_write_mask = r_mask;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus multi-cycle corner sequences.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic CLK, RST;
  int   n_chk, n_err;

  mem_arbiter_if #(.PORT_COUNT(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.PORT_COUNT(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  f0, f1;
    logic [31:0] a0, a1;
    logic [31:0] rdata;
    int          gnt;
    logic [1:0]  mflag;
    logic [31:0] maddr;
  } vec_t;

  localparam logic [31:0] WD0 = 32'h1111_1111;
  localparam logic [31:0] WD1 = 32'h2222_2222;

  vec_t        vt[6];
  logic [31:0] last_rd[2];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_rw_flag    = '0;
    bus.req_addr       = '0;
    bus.req_write_data = '0;
    bus.req_write_mask = '0;
    bus.MEM_read_data  = '0;
    bus.MEM_busy       = 1'b0;
    bus.MEM_done       = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    step();
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic pulse_done(input logic [31:0] rd);
    bus.MEM_done      = 1'b1;
    bus.MEM_read_data = rd;
    step();
    bus.MEM_done = 1'b0;
  endtask

  // returns when the downstream flag becomes active, or fails after a bound
  task automatic wait_serve(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.MEM_rw_flag != MEM_IDLE) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    bit ok;
    int g, pulses;
    n_chk = 0;
    n_err = 0;
    clear_inputs();

    // pointer starts at 0; each row's grant follows from the previous rows
    vt[0] = '{2'b01, 2'b00, 32'h0000_1000, 32'h0,  32'hDEAD_BEEF, 0, 2'b01, 32'h0000_1000};
    vt[1] = '{2'b01, 2'b10, 32'h10,        32'h20, 32'h0BAD_F00D, 1, 2'b10, 32'h20};
    vt[2] = '{2'b01, 2'b10, 32'h10,        32'h20, 32'h1234_5678, 0, 2'b01, 32'h10};
    vt[3] = '{2'b01, 2'b00, 32'h14,        32'h0,  32'hA5A5_A5A5, 0, 2'b01, 32'h14};
    vt[4] = '{2'b11, 2'b01, 32'h18,        32'h30, 32'h5A5A_5A5A, 1, 2'b01, 32'h30};
    vt[5] = '{2'b01, 2'b11, 32'h40,        32'h44, 32'hFEED_FACE, 0, 2'b01, 32'h40};

    RST = 1'b1;
    #2;
    chk("rst_mem_flag", 64'(bus.MEM_rw_flag), 64'(0));
    chk("rst_done", 64'(bus.req_done), 64'(0));
    chk("rst_busy", 64'(bus.req_busy), 64'(0));
    chk("rst_rdata", 64'(bus.req_read_data), 64'(0));
    chk("rst_addr", 64'(bus.MEM_addr), 64'(0));
    do_reset();

    for (int k = 0; k < 6; k++) begin
      bus.req_rw_flag[0]    = vt[k].f0;
      bus.req_rw_flag[1]    = vt[k].f1;
      bus.req_addr[0]       = vt[k].a0;
      bus.req_addr[1]       = vt[k].a1;
      bus.req_write_data[0] = WD0;
      bus.req_write_data[1] = WD1;
      bus.req_write_mask[0] = 4'h3;
      bus.req_write_mask[1] = 4'hC;
      step();
      chk("vec_flag", 64'(bus.MEM_rw_flag), 64'(vt[k].mflag));
      chk("vec_addr", 64'(bus.MEM_addr), 64'(vt[k].maddr));
      chk("vec_wdata", 64'(bus.MEM_write_data), 64'(vt[k].gnt == 1 ? WD1 : WD0));
      chk("vec_mask", 64'(bus.MEM_write_mask), 64'(vt[k].gnt == 1 ? 4'hC : 4'h3));
      chk("vec_busy", 64'(bus.req_busy), 64'(vt[k].gnt == 1 ? 2'b01 : 2'b10));
      step();
      step();
      chk("vec_hold_flag", 64'(bus.MEM_rw_flag), 64'(vt[k].mflag));
      pulse_done(vt[k].rdata);
      last_rd[vt[k].gnt] = vt[k].rdata;
      chk("vec_done", 64'(bus.req_done), 64'(vt[k].gnt == 1 ? 2'b10 : 2'b01));
      chk("vec_rd0", 64'(bus.req_read_data[0]), 64'(last_rd[0]));
      chk("vec_rd1", 64'(bus.req_read_data[1]), 64'(last_rd[1]));
      chk("vec_resp_flag", 64'(bus.MEM_rw_flag), 64'(0));
      bus.req_rw_flag = '0;
      step();
      chk("vec_gap_flag", 64'(bus.MEM_rw_flag), 64'(0));
      chk("vec_gap_done", 64'(bus.req_done), 64'(0));
      step();
      chk("vec_idle_busy", 64'(bus.req_busy), 64'(0));
    end

    // contention straight out of reset, write passes through unchanged
    do_reset();
    bus.req_rw_flag[0]    = MEM_READ;
    bus.req_addr[0]       = 32'h10;
    bus.req_rw_flag[1]    = MEM_WRITE;
    bus.req_addr[1]       = 32'h20;
    bus.req_write_data[1] = 32'hCAFE_F00D;
    bus.req_write_mask[1] = 4'hF;
    step();
    chk("cont_p0_flag", 64'(bus.MEM_rw_flag), 64'(MEM_READ));
    chk("cont_p0_addr", 64'(bus.MEM_addr), 64'(32'h10));
    chk("cont_p0_busy", 64'(bus.req_busy), 64'(2'b10));
    step();
    pulse_done(32'h0000_0077);
    chk("cont_p0_done", 64'(bus.req_done), 64'(2'b01));
    bus.req_rw_flag[0] = MEM_IDLE;
    wait_serve("cont_p1", ok);
    chk("cont_p1_flag", 64'(bus.MEM_rw_flag), 64'(MEM_WRITE));
    chk("cont_p1_addr", 64'(bus.MEM_addr), 64'(32'h20));
    chk("cont_p1_wdata", 64'(bus.MEM_write_data), 64'(32'hCAFE_F00D));
    chk("cont_p1_mask", 64'(bus.MEM_write_mask), 64'(4'hF));
    chk("cont_p1_busy", 64'(bus.req_busy), 64'(2'b01));
    pulse_done(32'h0);
    chk("cont_p1_done", 64'(bus.req_done), 64'(2'b10));
    bus.req_rw_flag = '0;
    step();
    step();

    // fairness with both requesters always asking
    do_reset();
    bus.req_rw_flag[0] = MEM_READ;
    bus.req_rw_flag[1] = MEM_READ;
    for (int k = 0; k < 6; k++) begin
      wait_serve("fair", ok);
      g = bus.req_busy[0] ? 1 : 0;
      chk("fair_grant", 64'(g), 64'(k % 2));
      pulse_done(32'(k));
      chk("fair_done", 64'(bus.req_done), 64'(k % 2 == 1 ? 2'b10 : 2'b01));
    end
    bus.req_rw_flag = '0;
    step();
    step();

    // MEM_busy holds off the grant
    do_reset();
    bus.MEM_busy       = 1'b1;
    bus.req_rw_flag[1] = MEM_READ;
    bus.req_addr[1]    = 32'h50;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("busy_gate_flag", 64'(bus.MEM_rw_flag), 64'(0));
    end
    bus.MEM_busy = 1'b0;
    step();
    chk("busy_release_flag", 64'(bus.MEM_rw_flag), 64'(MEM_READ));
    chk("busy_release_addr", 64'(bus.MEM_addr), 64'(32'h50));
    pulse_done(32'h0000_5050);
    chk("busy_done", 64'(bus.req_done), 64'(2'b10));
    bus.req_rw_flag = '0;
    step();
    step();

    // requester walks away mid-transaction; it still completes exactly once
    bus.req_rw_flag[0] = MEM_READ;
    bus.req_addr[0]    = 32'h60;
    step();
    chk("abandon_flag", 64'(bus.MEM_rw_flag), 64'(MEM_READ));
    bus.req_rw_flag[0] = MEM_IDLE;
    step();
    chk("abandon_hold", 64'(bus.MEM_rw_flag), 64'(MEM_READ));
    pulse_done(32'h0000_6060);
    chk("abandon_done", 64'(bus.req_done), 64'(2'b01));
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.req_done != 0 || bus.MEM_rw_flag != 0) pulses++;
    end
    chk("abandon_quiet", 64'(pulses), 64'(0));

    // reset during SERVE, then a stray done
    bus.req_rw_flag[1] = MEM_READ;
    bus.req_addr[1]    = 32'h70;
    step();
    chk("rmid_serve_busy", 64'(bus.req_busy), 64'(2'b01));
    RST = 1'b1;
    #1;
    chk("rmid_flag", 64'(bus.MEM_rw_flag), 64'(0));
    chk("rmid_busy", 64'(bus.req_busy), 64'(0));
    chk("rmid_rdata", 64'(bus.req_read_data), 64'(0));
    chk("rmid_addr", 64'(bus.MEM_addr), 64'(0));
    bus.req_rw_flag = '0;
    step();
    RST = 1'b0;
    step();
    pulse_done(32'hBAD0_BAD0);
    chk("rmid_stray_done", 64'(bus.req_done), 64'(0));
    step();
    chk("rmid_stray_done2", 64'(bus.req_done), 64'(0));
    bus.req_rw_flag[0] = MEM_READ;
    bus.req_rw_flag[1] = MEM_READ;
    step();
    chk("rmid_regrant_busy", 64'(bus.req_busy), 64'(2'b10));
    pulse_done(32'h0);
    chk("rmid_regrant_done", 64'(bus.req_done), 64'(2'b01));
    bus.req_rw_flag = '0;
    step();
    step();

    // illegal flag is never granted
    bus.req_rw_flag[0] = 2'b11;
    bus.req_rw_flag[1] = 2'b11;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.MEM_rw_flag != 0 || bus.req_busy != 0 || bus.req_done != 0) pulses++;
    end
    chk("illegal_idle", 64'(pulses), 64'(0));
    bus.req_rw_flag = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
